cpu_scoreboard_regfile: RTL and testbench

Parametrised integer register file for the pipelined CPU core, replacing the fixed 32×32 file. It adds a synchronous reset that zeroes every register through a hardware clear sequence, a per-register pending scoreboard for hazard detection, and optional write-to-read bypass. Register 0 is hardwired to zero. It sits between decode (reads, issue marking) and writeback (writes).

---
 rtl/cpu_scoreboard_regfile.sv | 114 +++++++++++
 tb/tb_cpu_scoreboard_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_scoreboard_regfile.sv
// rtl/cpu_scoreboard_regfile.sv - parametrised register file with clear sequence, pending scoreboard and optional write bypass
module cpu_scoreboard_regfile #(
    parameter int XLEN   = 32,
    parameter int REGS   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            pend1,
    output logic            pend2,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic            we3,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            ready,
    output logic            pend_any
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(REGS - 1);

    state_t          state, state_next;
    logic [AW-1:0]   idx, idx_next;
    logic [REGS-1:0] pend_q, pend_next;
    logic [XLEN-1:0] regs [REGS];

    logic run, wr_en, iss_en, byp1, byp2;

    assign run    = (state == RUN);
    assign wr_en  = run && we3 && (a3 != '0);
    assign iss_en = run && iss_valid && (iss_rd != '0);
    assign byp1   = (BYPASS != 0) && wr_en && (a3 == a1);
    assign byp2   = (BYPASS != 0) && wr_en && (a3 == a2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            idx    <= AW'(1);
            pend_q <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            pend_q <= pend_next;
        end
    end

    // Issue is applied after the write so a newer producer keeps the bit set.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        pend_next  = pend_q;
        case (state)
            CLEAR: begin
                idx_next = idx + AW'(1);
                if (idx == LAST)
                    state_next = RUN;
            end
            RUN: begin
                if (wr_en)
                    pend_next[a3] = 1'b0;
                if (iss_en)
                    pend_next[iss_rd] = 1'b1;
            end
            default: state_next = CLEAR;
        endcase
    end

    // Register 0 is never written; reads of it are masked below.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                regs[idx] <= '0;
            else if (wr_en)
                regs[a3] <= wd3;
        end
    end

    always_comb begin
        rd1   = '0;
        pend1 = 1'b0;
        if (run && (a1 != '0)) begin
            if (byp1) begin
                rd1   = wd3;
                pend1 = iss_en && (iss_rd == a1);
            end else begin
                rd1   = regs[a1];
                pend1 = pend_q[a1];
            end
        end
    end

    always_comb begin
        rd2   = '0;
        pend2 = 1'b0;
        if (run && (a2 != '0)) begin
            if (byp2) begin
                rd2   = wd3;
                pend2 = iss_en && (iss_rd == a2);
            end else begin
                rd2   = regs[a2];
                pend2 = pend_q[a2];
            end
        end
    end

    assign ready    = run;
    assign pend_any = run && (|pend_q);
endmodule

// File: tb/tb_cpu_scoreboard_regfile.sv
// tb/tb_cpu_scoreboard_regfile.sv - self-checking bench for cpu_scoreboard_regfile (bypass and non-bypass instances)
module tb_cpu_scoreboard_regfile;
    localparam int XLEN = 32;
    localparam int REGS = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   a1, a2, a3, iss_rd;
    logic [XLEN-1:0] wd3;
    logic            we3, iss_valid;

    logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic            pend1_b, pend2_b, ready_b, pend_any_b;
    logic            pend1_n, pend2_n, ready_n, pend_any_n;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    cpu_scoreboard_regfile #(.XLEN(XLEN), .REGS(REGS), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b),
        .pend1(pend1_b), .pend2(pend2_b), .a3(a3), .wd3(wd3), .we3(we3),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .ready(ready_b), .pend_any(pend_any_b)
    );

    cpu_scoreboard_regfile #(.XLEN(XLEN), .REGS(REGS), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1_n), .rd2(rd2_n),
        .pend1(pend1_n), .pend2(pend2_n), .a3(a3), .wd3(wd3), .we3(we3),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .ready(ready_n), .pend_any(pend_any_n)
    );

    // Architectural model: clearing counts edges since reset; registers all read zero once it ends.
    logic [XLEN-1:0] m_regs [REGS];
    bit              m_pend [REGS];
    bit              m_run = 0;
    int              m_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 0;
            m_cnt <= 0;
            for (int i = 0; i < REGS; i++) m_pend[i] <= 0;
        end else if (!m_run) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == REGS - 1) begin
                m_run <= 1;
                for (int i = 0; i < REGS; i++) m_regs[i] <= '0;
            end
        end else begin
            if (we3 && a3 != 0) begin
                m_regs[a3] <= wd3;
                m_pend[a3] <= 0;
            end
            if (iss_valid && iss_rd != 0) m_pend[iss_rd] <= 1;
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (!m_run || a == 0) return '0;
        if (byp && we3 && a3 == a) return wd3;
        return m_regs[a];
    endfunction

    function automatic logic exp_pend(input logic [AW-1:0] a, input bit byp);
        if (!m_run || a == 0) return 1'b0;
        if (byp && we3 && a3 == a) return iss_valid && iss_rd == a;
        return m_pend[a];
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int i = 0; i < REGS; i++) r = r | m_pend[i];
        return m_run && r;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("rd1_b", rd1_b, exp_rd(a1, 1));
            check("rd2_b", rd2_b, exp_rd(a2, 1));
            check("pend1_b", 32'(pend1_b), 32'(exp_pend(a1, 1)));
            check("pend2_b", 32'(pend2_b), 32'(exp_pend(a2, 1)));
            check("ready_b", 32'(ready_b), 32'(m_run));
            check("pend_any_b", 32'(pend_any_b), 32'(exp_any()));
            check("rd1_n", rd1_n, exp_rd(a1, 0));
            check("rd2_n", rd2_n, exp_rd(a2, 0));
            check("pend1_n", 32'(pend1_n), 32'(exp_pend(a1, 0)));
            check("pend2_n", 32'(pend2_n), 32'(exp_pend(a2, 0)));
            check("ready_n", 32'(ready_n), 32'(m_run));
            check("pend_any_n", 32'(pend_any_n), 32'(exp_any()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we3 = 0; iss_valid = 0;
    endtask

    initial begin
        rst = 1; a1 = 0; a2 = 0; a3 = 0; iss_rd = 0; wd3 = '0; we3 = 0; iss_valid = 0;
        step();
        checking = 1;
        check("reset_ready", 32'(ready_b), 32'd0);
        check("reset_rd1", rd1_b, 32'd0);
        check("reset_pend_any", 32'(pend_any_b), 32'd0);
        rst = 0;
        // Reset in the middle of clearing restarts the count.
        for (int i = 0; i < 10; i++) step();
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 30; i++) step();
        check("clear_30_edges_not_ready", 32'(ready_b), 32'd0);
        step();
        check("clear_31_edges_ready", 32'(ready_b), 32'd1);

        // Preload every register
        we3 = 1;
        for (int i = 1; i < REGS; i++) begin
            a3 = AW'(i); wd3 = 32'h0101_0101 * i; step();
        end
        idle();
        a1 = 5; #1;
        check("preload_x5", rd1_b, 32'h0505_0505);

        // Clear sequence wipes the preload; writes and issues during clear are dropped
        rst = 1; step(); rst = 0;
        we3 = 1; a3 = 4; wd3 = 32'hCAFE_0004; iss_valid = 1; iss_rd = 6;
        for (int i = 0; i < REGS - 1; i++) step();
        idle();
        check("clear_ready", 32'(ready_b), 32'd1);
        check("clear_no_pend", 32'(pend_any_b), 32'd0);
        for (int i = 1; i < REGS; i++) begin
            a1 = AW'(i); #1;
            check("cleared_reg", rd1_b, 32'd0);
        end

        // Basic write/read and register 0
        a3 = 5; wd3 = 32'hDEAD_BEEF; we3 = 1; step(); idle();
        a1 = 5; #1;
        check("x5_readback", rd1_b, 32'hDEAD_BEEF);
        check("x5_readback_n", rd1_n, 32'hDEAD_BEEF);
        a3 = 0; wd3 = 32'h1234; we3 = 1; iss_valid = 1; iss_rd = 0; a2 = 0; #1;
        check("x0_bypass", rd2_b, 32'd0);
        step(); idle(); #1;
        check("x0_read", rd2_b, 32'd0);
        check("x0_pend", 32'(pend2_b), 32'd0);

        // Scoreboard set and clear
        iss_valid = 1; iss_rd = 7; step(); idle();
        a1 = 7; #1;
        check("x7_pend", 32'(pend1_b), 32'd1);
        check("x7_pend_any", 32'(pend_any_b), 32'd1);
        we3 = 1; a3 = 7; wd3 = 32'h55; #1;
        check("x7_bypass_pend", 32'(pend1_b), 32'd0);
        check("x7_nobypass_pend", 32'(pend1_n), 32'd1);
        step(); idle(); #1;
        check("x7_pend_cleared", 32'(pend1_b), 32'd0);
        check("x7_pend_any_cleared", 32'(pend_any_b), 32'd0);
        check("x7_value", rd1_b, 32'h55);

        // Simultaneous write and issue on a pending register
        iss_valid = 1; iss_rd = 9; step(); idle();
        we3 = 1; a3 = 9; wd3 = 32'hAA; iss_valid = 1; iss_rd = 9; a1 = 9; #1;
        check("x9_bypass_rd", rd1_b, 32'hAA);
        check("x9_bypass_pend", 32'(pend1_b), 32'd1);
        check("x9_nobypass_rd", rd1_n, 32'd0);
        step(); idle(); #1;
        check("x9_rd_after", rd1_b, 32'hAA);
        check("x9_pend_after", 32'(pend1_b), 32'd1);
        check("x9_pend_after_n", 32'(pend1_n), 32'd1);

        // Bypass versus stored-state read
        we3 = 1; a3 = 12; wd3 = 32'h1111; step();
        a2 = 12; wd3 = 32'h0F0F; #1;
        check("x12_bypass", rd2_b, 32'h0F0F);
        check("x12_nobypass_old", rd2_n, 32'h1111);
        step(); idle(); #1;
        check("x12_nobypass_new", rd2_n, 32'h0F0F);

        // Reset mid-run drops pending bits and wipes contents
        we3 = 1; a3 = 3; wd3 = 32'h77; step(); idle();
        iss_valid = 1; iss_rd = 3; step(); idle();
        a1 = 3; #1;
        check("x3_pend_before", 32'(pend1_b), 32'd1);
        check("x3_value_before", rd1_b, 32'h77);
        rst = 1; step(); rst = 0; #1;
        check("rst_ready_low", 32'(ready_b), 32'd0);
        check("rst_pend_any_low", 32'(pend_any_b), 32'd0);
        for (int i = 0; i < REGS - 1; i++) step();
        check("rerun_ready", 32'(ready_b), 32'd1);
        check("x3_after_clear", rd1_b, 32'd0);
        check("x3_pend_after_clear", 32'(pend1_b), 32'd0);
        a1 = 9; #1;
        check("x9_pend_after_clear", 32'(pend1_b), 32'd0);
        step();

        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
